data_sram_resp: RTL

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

---
 rtl/data_sram_resp_pkg.sv | 14 +
 rtl/data_sram_resp_bank.sv | 39 +++
 rtl/data_sram_resp.sv | 106 ++++++++++
 3 files changed

// File: rtl/data_sram_resp_pkg.sv
// Shared defines for the data-SRAM response path: bus widths, byte-lane count
// and the wait-state FSM encoding.
package data_sram_resp_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int BUS_ADDR_WIDTH = 32;
  localparam int BYTE_LANES     = DATA_WIDTH / 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } dsram_state_e;

endpackage

// File: rtl/data_sram_resp_bank.sv
// dsram_bank: single-port byte-enable synchronous RAM with a registered read
// port that holds its value on writes and idle cycles.
module dsram_bank
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [BYTE_LANES-1:0] wen,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset branch so it maps onto block RAM; only the
  // read register below is cleared.
  always_ff @(posedge clk) begin
    if (en && (wen != '0)) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
        if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (en && (wen == '0)) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data-SRAM response block: word-indexed RAM plus optional wait-state injection
// enabled by the DSRAM_WAIT_EN macro (with WAIT_CYCLES > 0).
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_WIDTH  = 14,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      data_sram_en,
  input  logic [BYTE_LANES-1:0]     data_sram_wen,
  input  logic [BUS_ADDR_WIDTH-1:0] data_sram_addr,
  input  logic [DATA_WIDTH-1:0]     data_sram_wdata,
  output logic [DATA_WIDTH-1:0]     data_sram_rdata,
  output logic                      stallreq
);

`ifdef DSRAM_WAIT_EN
  localparam bit WAIT_ACTIVE = (WAIT_CYCLES > 0);
`else
  localparam bit WAIT_ACTIVE = 1'b0;
`endif

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  unused_addr_bits;

  logic                  bank_en;
  logic [BYTE_LANES-1:0] bank_wen;
  logic [ADDR_WIDTH-1:0] bank_addr;
  logic [DATA_WIDTH-1:0] bank_wdata;

  // Byte offset and high address bits are dropped, so upper addresses alias.
  assign word_idx         = data_sram_addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{data_sram_addr[BUS_ADDR_WIDTH-1:ADDR_WIDTH+2],
                              data_sram_addr[1:0]};

  generate
    if (WAIT_ACTIVE) begin : g_wait
      localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
      localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

      dsram_state_e          state_q;
      logic [CNT_W-1:0]      cnt_q;
      logic [BYTE_LANES-1:0] wen_q;
      logic [ADDR_WIDTH-1:0] idx_q;
      logic [DATA_WIDTH-1:0] wdata_q;

      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge value of its neighbours.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          wen_q   <= '0;
          idx_q   <= '0;
          wdata_q <= '0;
        end else begin
          case (state_q)
            IDLE: begin
              if (data_sram_en) begin
                wen_q   <= data_sram_wen;
                idx_q   <= word_idx;
                wdata_q <= data_sram_wdata;
                cnt_q   <= CNT_LOAD;
                state_q <= BUSY;
              end
            end
            BUSY: begin
              if (cnt_q == '0) state_q <= IDLE;
              else             cnt_q   <= cnt_q - 1'b1;
            end
            default: state_q <= IDLE;
          endcase
        end
      end

      // The latched request fires on the last BUSY edge; reset drops it.
      assign bank_en    = (state_q == BUSY) && (cnt_q == '0) && !rst;
      assign bank_wen   = wen_q;
      assign bank_addr  = idx_q;
      assign bank_wdata = wdata_q;
      assign stallreq   = ((state_q == IDLE) && data_sram_en) ||
                          ((state_q == BUSY) && (cnt_q != '0));
    end else begin : g_direct
      assign bank_en    = data_sram_en && !rst;
      assign bank_wen   = data_sram_wen;
      assign bank_addr  = word_idx;
      assign bank_wdata = data_sram_wdata;
      assign stallreq   = 1'b0;
    end
  endgenerate

  dsram_bank #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .en    (bank_en),
    .wen   (bank_wen),
    .addr  (bank_addr),
    .wdata (bank_wdata),
    .rdata (data_sram_rdata)
  );

endmodule
